// File: rtl/vga_stream_monitor.sv
// vga_stream_monitor: checks sync widths, line/frame periods and OX/OY against its own raster counters, and reports a lit-pixel count per frame; define VGA_MON_CRC_EN to build the per-frame CRC-16 of active pixels.
module vga_stream_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIX_DIV = 1,
  parameter int RGB_W = 12,
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic             clk,
  input  logic             Mreset,
  input  logic             enable,
  input  logic             h_sync,
  input  logic             v_sync,
  input  logic [RGB_W-1:0] RGBA,
  input  logic [X_W-1:0]   OX,
  input  logic [Y_W-1:0]   OY,
  output logic             locked,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic [19:0]      lit_count,
  output logic [15:0]      frame_crc,
  output logic [4:0]       err
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W = $clog2(H_TOT + 1);
  localparam int VC_W = $clog2(V_TOT + 1);
  localparam int DC_W = $clog2(PIX_DIV + 1);
  localparam int HA0 = H_SYNC + H_BP;
  localparam int VA0 = V_SYNC + V_BP;
  localparam int PW = RGB_W + X_W + Y_W;
  typedef enum logic [1:0] {SEEK, ALIGN, MEASURE} state_t;
  state_t state;
  logic [1:0] s1, s2, a, a_q;
  logic [PW-1:0] pd1, pd2;
  logic [RGB_W-1:0] rgb;
  logic [X_W-1:0] ox;
  logic [Y_W-1:0] oy;
  logic hs_on, hs_off, vs_on, vs_off, tick, act, meas, fe;
  logic [DC_W-1:0] div, div_n;
  logic [HC_W-1:0] hcnt, px;
  logic [VC_W-1:0] vcnt, ln;
  logic [19:0] lit_run;
  logic [4:0] e, err_n;
  // pixel data is delayed by the same two stages as the sync synchroniser
  always_ff @(posedge clk or posedge Mreset)
    if (Mreset) begin
      s1 <= {2{~SYNC_POL}};
      s2 <= {2{~SYNC_POL}};
      a_q <= '0;
      pd1 <= '0;
      pd2 <= '0;
    end else begin
      s1 <= {h_sync, v_sync};
      s2 <= s1;
      a_q <= a;
      pd1 <= {RGBA, OX, OY};
      pd2 <= pd1;
    end
  assign a = ~(s2 ^ {2{SYNC_POL}});
  assign {rgb, ox, oy} = pd2;
  assign hs_on = a[1] & ~a_q[1];
  assign hs_off = ~a[1] & a_q[1];
  assign vs_on = a[0] & ~a_q[0];
  assign vs_off = ~a[0] & a_q[0];
  // px/ln are the current pixel and line indices; the edge cycle itself is pixel 0
  always_comb begin
    tick = hs_on || div == '0;
    div_n = hs_on ? DC_W'(PIX_DIV > 1) : (div == DC_W'(PIX_DIV - 1)) ? '0 : div + 1'b1;
    px = hs_on ? '0 : (tick && hcnt != '1) ? hcnt + 1'b1 : hcnt;
    ln = vs_on ? '0 : (hs_on && vcnt != '1) ? vcnt + 1'b1 : vcnt;
    meas = state == MEASURE;
    act = meas && tick && px >= HC_W'(HA0) && px < HC_W'(HA0 + H_ACTIVE)
          && ln >= VC_W'(VA0) && ln < VC_W'(VA0 + V_ACTIVE);
    fe = meas && vs_on;
    e = {act && (ox != X_W'(px - HC_W'(HA0)) || oy != Y_W'(ln - VC_W'(VA0))),
         vs_on && vcnt != VC_W'(V_TOT - 1),
         vs_off && ln != VC_W'(V_SYNC),
         hs_on && hcnt != HC_W'(H_TOT - 1),
         hs_off && px != HC_W'(H_SYNC)};
    err_n = err | (meas ? e : '0);
  end
  always_ff @(posedge clk or posedge Mreset)
    if (Mreset) begin
      state <= SEEK;
      div <= '0;
      hcnt <= '0;
      vcnt <= '0;
      lit_run <= '0;
      err <= '0;
      locked <= 1'b0;
      frame_done <= 1'b0;
      frame_count <= '0;
      lit_count <= '0;
    end else if (!enable) begin
      state <= SEEK;
      frame_done <= 1'b0;
    end else begin
      state <= !vs_on ? state : (state == SEEK) ? ALIGN : MEASURE;
      div <= div_n;
      hcnt <= px;
      vcnt <= ln;
      lit_run <= vs_on ? '0 : lit_run + 20'(act && |rgb && ~&lit_run);
      err <= err_n;
      locked <= |err_n ? 1'b0 : (fe | locked);
      frame_done <= fe;
      if (fe) begin
        lit_count <= lit_run;
        frame_count <= frame_count + 1'b1;
      end
    end
`ifdef VGA_MON_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [RGB_W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int i = RGB_W - 1; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  logic [15:0] crc_run;
  always_ff @(posedge clk or posedge Mreset)
    if (Mreset) begin
      crc_run <= 16'hFFFF;
      frame_crc <= '0;
    end else if (enable) begin
      crc_run <= vs_on ? 16'hFFFF : act ? crc_step(crc_run, rgb) : crc_run;
      if (fe) frame_crc <= crc_run;
    end
`else
  assign frame_crc = '0;
`endif
endmodule
